// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin values, change-dispenser FSM
// states and the one-hot coin-select type used by the credit and change logic.
package vm_pkg;

  // Coin values in cents.
  localparam int unsigned COIN_DOLLAR  = 100;
  localparam int unsigned COIN_QUARTER = 25;
  localparam int unsigned COIN_DIME    = 10;
  localparam int unsigned COIN_NICKEL  = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } disp_state_e;

  // One-hot coin select; dollar is the MSB so the packed value reads {D,Q,Di,N}.
  typedef struct packed {
    logic dollar;
    logic quarter;
    logic dime;
    logic nickel;
  } coin_sel_t;

  // Value in cents of a one-hot coin select (zero when nothing is selected).
  function automatic int unsigned coin_value(input coin_sel_t sel);
    int unsigned val;
    val = 0;
    if (sel.dollar)       val = COIN_DOLLAR;
    else if (sel.quarter) val = COIN_QUARTER;
    else if (sel.dime)    val = COIN_DIME;
    else if (sel.nickel)  val = COIN_NICKEL;
    return val;
  endfunction

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter that reports expiry; times eject pulses and gaps.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       load load_val_i this cycle (takes priority over counting)
//   load_val_i   cycles-minus-one to time
//   expired_c_o  combinational: counter has reached zero
module dispense_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c_o = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: turns a change amount in cents into greedy coin-eject
// pulses (dollar, quarter, dime, nickel), then strobes done with the coin
// count and an odd-cents flag for the 0-4 cent residue that cannot be paid.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid, req_amt         change request (held until req_ready)
//   req_ready                  high only while idle
//   eject_dollar/quarter/
//   eject_dime/nickel          one-hot (or zero) eject pulses
//   busy                       acceptance through the done cycle
//   done                       one-cycle completion strobe
//   odd_cents, coins_out       transaction results, valid with done
// Optional build macro CHANGE_INVENTORY_EN adds per-coin stock tracking:
//   stock_load                 reload all stocks (deferred until idle)
//   shortfall, shortfall_amt   unpayable remainder, valid with done
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned AMT_W        = 9,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2
`ifdef CHANGE_INVENTORY_EN
  ,
  parameter int unsigned STOCK_W      = 6,
  parameter int unsigned STOCK_INIT   = 40
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amt,
  output logic             req_ready,
  output logic             eject_dollar,
  output logic             eject_quarter,
  output logic             eject_dime,
  output logic             eject_nickel,
  output logic             busy,
  output logic             done,
  output logic             odd_cents,
  output logic [3:0]       coins_out
`ifdef CHANGE_INVENTORY_EN
  ,
  input  logic             stock_load,
  output logic             shortfall,
  output logic [AMT_W-1:0] shortfall_amt
`endif
);

  localparam int unsigned TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [AMT_W-1:0] AMT_DOLLAR  = AMT_W'(COIN_DOLLAR);
  localparam logic [AMT_W-1:0] AMT_QUARTER = AMT_W'(COIN_QUARTER);
  localparam logic [AMT_W-1:0] AMT_DIME    = AMT_W'(COIN_DIME);
  localparam logic [AMT_W-1:0] AMT_NICKEL  = AMT_W'(COIN_NICKEL);

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [3:0]       coins_q, coins_d;
  logic             odd_q, odd_d;
  coin_sel_t        eject_q, eject_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_expired;

  coin_sel_t        avail;
  coin_sel_t        pick;
  logic [AMT_W-1:0] pick_amt;
  logic             take_coin;

`ifdef CHANGE_INVENTORY_EN
  logic             sf_q, sf_d;
  logic [AMT_W-1:0] sf_amt_q, sf_amt_d;
`endif

  dispense_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (tmr_load),
    .load_val_i  (tmr_val),
    .expired_c_o (tmr_expired)
  );

  // Greedy pick: largest available coin not exceeding the remainder.
  always_comb begin
    pick = '0;
    if (avail.dollar && (rem_q >= AMT_DOLLAR)) begin
      pick.dollar = 1'b1;
    end else if (avail.quarter && (rem_q >= AMT_QUARTER)) begin
      pick.quarter = 1'b1;
    end else if (avail.dime && (rem_q >= AMT_DIME)) begin
      pick.dime = 1'b1;
    end else if (avail.nickel && (rem_q >= AMT_NICKEL)) begin
      pick.nickel = 1'b1;
    end
    pick_amt = AMT_W'(coin_value(pick));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    coins_d   = coins_q;
    odd_d     = odd_q;
    eject_d   = '0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    take_coin = 1'b0;
`ifdef CHANGE_INVENTORY_EN
    sf_d      = sf_q;
    sf_amt_d  = sf_amt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d  = ST_SELECT;
          rem_d    = req_amt;
          odd_d    = ((req_amt % AMT_NICKEL) != '0);
          coins_d  = '0;
`ifdef CHANGE_INVENTORY_EN
          sf_d     = 1'b0;
          sf_amt_d = '0;
`endif
        end
      end
      ST_SELECT: begin
        if (pick != '0) begin
          state_d   = ST_PULSE;
          take_coin = 1'b1;
          rem_d     = rem_q - pick_amt;
          coins_d   = (coins_q == 4'hF) ? coins_q : coins_q + 4'd1;
          eject_d   = pick;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(PULSE_CYCLES - 1);
        end else begin
          state_d = ST_DONE;
`ifdef CHANGE_INVENTORY_EN
          // Payable amount left but every fitting coin is out of stock.
          if (rem_q >= AMT_NICKEL) begin
            sf_d     = 1'b1;
            sf_amt_d = rem_q;
          end
`endif
        end
      end
      ST_PULSE: begin
        eject_d = eject_q;
        if (tmr_expired) begin
          state_d  = ST_GAP;
          eject_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        if (tmr_expired) begin
          state_d = ST_SELECT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they align with it.
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      coins_q <= '0;
      odd_q   <= 1'b0;
      eject_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      coins_q <= coins_d;
      odd_q   <= odd_d;
      eject_q <= eject_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef CHANGE_INVENTORY_EN
  // Stock per coin, index order matches coin_sel_t bits {D,Q,Di,N}.
  logic [3:0][STOCK_W-1:0] stock_q, stock_d;
  logic                    load_pend_q, load_pend_d;
  logic [3:0]              pick_v;
  logic [3:0]              avail_v;

  assign pick_v = pick;

  // Reloads only take effect while idle; a request seen while busy is held.
  always_comb begin
    stock_d     = stock_q;
    load_pend_d = load_pend_q;
    if (state_q == ST_IDLE) begin
      load_pend_d = 1'b0;
      if (stock_load || load_pend_q) begin
        for (int i = 0; i < 4; i++) begin
          stock_d[i] = STOCK_W'(STOCK_INIT);
        end
      end
    end else begin
      load_pend_d = load_pend_q | stock_load;
      if (take_coin) begin
        for (int i = 0; i < 4; i++) begin
          if (pick_v[i]) begin
            stock_d[i] = stock_q[i] - STOCK_W'(1);
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      avail_v[i] = (stock_q[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end
      load_pend_q <= 1'b0;
      sf_q        <= 1'b0;
      sf_amt_q    <= '0;
    end else begin
      stock_q     <= stock_d;
      load_pend_q <= load_pend_d;
      sf_q        <= sf_d;
      sf_amt_q    <= sf_amt_d;
    end
  end

  assign avail         = coin_sel_t'(avail_v);
  assign shortfall     = sf_q;
  assign shortfall_amt = sf_amt_q;
`else
  // Unlimited stock: every denomination is always available.
  assign avail = '1;
`endif

  assign req_ready     = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign odd_cents     = odd_q;
  assign coins_out     = coins_q;
  assign eject_dollar  = eject_q.dollar;
  assign eject_quarter = eject_q.quarter;
  assign eject_dime    = eject_q.dime;
  assign eject_nickel  = eject_q.nickel;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: a greedy coin model fills an
// expected-coin queue per request; a monitor pops it on each eject pulse and
// checks pulse width, gap length and one-hotness; scenario tasks check the
// done timing and the result fields.
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int unsigned AMT_W = 9;
  localparam int          P     = 4;
  localparam int          G     = 2;
  localparam int          COIN_CYC = 1 + P + G;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b1;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amt   = '0;
  logic             req_ready;
  logic             eject_dollar, eject_quarter, eject_dime, eject_nickel;
  logic             busy, done, odd_cents;
  logic [3:0]       coins_out;
`ifdef CHANGE_INVENTORY_EN
  logic             stock_load = 1'b0;
  logic             shortfall;
  logic [AMT_W-1:0] shortfall_amt;
`endif

  change_dispenser #(
    .AMT_W        (AMT_W),
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_amt       (req_amt),
    .req_ready     (req_ready),
    .eject_dollar  (eject_dollar),
    .eject_quarter (eject_quarter),
    .eject_dime    (eject_dime),
    .eject_nickel  (eject_nickel),
    .busy          (busy),
    .done          (done),
    .odd_cents     (odd_cents),
    .coins_out     (coins_out)
`ifdef CHANGE_INVENTORY_EN
    ,
    .stock_load    (stock_load),
    .shortfall     (shortfall),
    .shortfall_amt (shortfall_amt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [3:0]  exp_q[$];
  int unsigned edge_cnt = 0;
  int unsigned acc_edge = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Pulse monitor: {dollar, quarter, dime, nickel}.
  logic [3:0]  ej;
  logic [3:0]  prev_ej   = '0;
  logic [3:0]  exp_coin;
  int          hi_cnt    = 0;
  int          lo_cnt    = 0;
  int unsigned last_fall = 0;
  assign ej = {eject_dollar, eject_quarter, eject_dime, eject_nickel};

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ej = '0;
      hi_cnt  = 0;
      lo_cnt  = 0;
    end else begin
      if (ej != 4'b0000 && prev_ej == 4'b0000) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: got %b required none", ej);
        end else begin
          exp_coin = exp_q.pop_front();
          if (ej !== exp_coin) begin
            failures++;
            $display("FAIL coin_order: got %b required %b", ej, exp_coin);
          end
        end
        if (last_fall > acc_edge) begin
          checks++;
          if (lo_cnt !== G + 1) begin
            failures++;
            $display("FAIL gap_len: got %0d required %0d", lo_cnt, G + 1);
          end
        end
        hi_cnt = 1;
      end else if (ej != 4'b0000) begin
        checks++;
        if (ej !== prev_ej) begin
          failures++;
          $display("FAIL pulse_stable: got %b required %b", ej, prev_ej);
        end
        hi_cnt++;
      end else if (prev_ej != 4'b0000) begin
        checks++;
        if (hi_cnt !== P) begin
          failures++;
          $display("FAIL pulse_width: got %0d required %0d", hi_cnt, P);
        end
        lo_cnt    = 1;
        last_fall = edge_cnt;
      end else begin
        lo_cnt++;
      end
      prev_ej = ej;
    end
  end

  // Greedy reference model: expected coin sequence and count.
  task automatic push_expected(input int amt, output int n);
    int r;
    r = amt;
    n = 0;
    while (r >= 100) begin exp_q.push_back(4'b1000); r -= 100; n++; end
    while (r >= 25)  begin exp_q.push_back(4'b0100); r -= 25;  n++; end
    while (r >= 10)  begin exp_q.push_back(4'b0010); r -= 10;  n++; end
    while (r >= 5)   begin exp_q.push_back(4'b0001); r -= 5;   n++; end
  endtask

  // Present a request and wait (bounded) for it to be accepted.
  task automatic send_req(input int amt, output bit ok);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_amt   = AMT_W'(amt);
    ok        = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    acc_edge = edge_cnt;
    #1;
    req_valid = 1'b0;
    req_amt   = '0;
  endtask

  // Cycles from the accept edge to the done cycle, or -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = int'(edge_cnt - acc_edge);
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b required 1", req_ready); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL rst_done: got %b required 0", done); end
    checks++; if (ej !== 4'b0000)     begin failures++; $display("FAIL rst_eject: got %b required 0000", ej); end
    checks++; if (odd_cents !== 1'b0) begin failures++; $display("FAIL rst_odd: got %b required 0", odd_cents); end
    checks++; if (coins_out !== 4'd0) begin failures++; $display("FAIL rst_coins: got %0d required 0", coins_out); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_greedy(input int amt);
    int n, cyc, exp_cyc;
    bit ok, exp_odd;
    push_expected(amt, n);
    exp_cyc = 1 + n * COIN_CYC + 1;
    exp_odd = (amt % 5) != 0;
    send_req(amt, ok);
    checks++; if (!ok) begin failures++; $display("FAIL accept_%0d: got no accept required accept", amt); end
    wait_done(cyc);
    checks++; if (cyc !== exp_cyc) begin failures++; $display("FAIL done_time_%0d: got %0d required %0d", amt, cyc, exp_cyc); end
    checks++; if (coins_out !== 4'(n)) begin failures++; $display("FAIL coins_%0d: got %0d required %0d", amt, coins_out, n); end
    checks++; if (odd_cents !== exp_odd) begin failures++; $display("FAIL odd_%0d: got %b required %b", amt, odd_cents, exp_odd); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL missing_coins_%0d: got %0d left required 0", amt, exp_q.size()); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL post_done_%0d: got busy=%b done=%b ready=%b required 0 0 1", amt, busy, done, req_ready);
    end
  endtask

  task automatic test_busy_ignore();
    int n, cyc;
    bit ok;
    push_expected(30, n);
    send_req(30, ok);
    repeat (4) @(negedge clk);
    checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL busy_flags: got ready=%b busy=%b required 0 1", req_ready, busy);
    end
    @(posedge clk); #1 req_valid = 1'b1; req_amt = AMT_W'(25);
    @(posedge clk); #1 req_valid = 1'b0; req_amt = '0;
    wait_done(cyc);
    checks++; if (cyc !== 1 + 2 * COIN_CYC + 1) begin failures++; $display("FAIL busy_done_time: got %0d required %0d", cyc, 1 + 2 * COIN_CYC + 1); end
    checks++; if (coins_out !== 4'd2) begin failures++; $display("FAIL busy_coins: got %0d required 2", coins_out); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_queued: got %b required 0", busy); end
  endtask

  task automatic test_back_to_back();
    int n, cyc;
    bit ok;
    push_expected(15, n);
    send_req(15, ok);
    wait_done(cyc);
    checks++; if (cyc !== 1 + 2 * COIN_CYC + 1) begin failures++; $display("FAIL b2b_first: got %0d required %0d", cyc, 1 + 2 * COIN_CYC + 1); end
    push_expected(5, n);
    send_req(5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_accept: got no accept required accept"); end
    wait_done(cyc);
    checks++; if (cyc !== 1 + COIN_CYC + 1) begin failures++; $display("FAIL b2b_second: got %0d required %0d", cyc, 1 + COIN_CYC + 1); end
    checks++; if (coins_out !== 4'd1 || exp_q.size() != 0) begin
      failures++; $display("FAIL b2b_coins: got %0d left=%0d required 1 left=0", coins_out, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_pulse();
    int n, cyc;
    bit ok, seen, done_seen;
    push_expected(40, n);
    send_req(40, ok);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (eject_quarter) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL mid_quarter: got 0 required 1"); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (eject_quarter !== 1'b0) begin failures++; $display("FAIL async_drop: got %b required 0", eject_quarter); end
    exp_q.delete();
    done_seen = 1'b0;
    repeat (3) begin @(negedge clk); if (done) done_seen = 1'b1; end
    #2 rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done) done_seen = 1'b1; end
    checks++; if (done_seen) begin failures++; $display("FAIL abandoned_done: got 1 required 0"); end
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL post_rst: got ready=%b busy=%b required 1 0", req_ready, busy);
    end
    push_expected(10, n);
    send_req(10, ok);
    wait_done(cyc);
    checks++; if (cyc !== 1 + COIN_CYC + 1) begin failures++; $display("FAIL rst_dime_time: got %0d required %0d", cyc, 1 + COIN_CYC + 1); end
    checks++; if (coins_out !== 4'd1 || exp_q.size() != 0) begin
      failures++; $display("FAIL rst_dime: got %0d left=%0d required 1 left=0", coins_out, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_greedy(65);
    test_greedy(500);
    test_greedy(0);
    test_greedy(67);
    test_greedy(4);
    test_greedy(95);
    test_greedy(511);
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
